key_pio_irq: RTL and testbench
==============================

# key_pio_irq

Parametrised successor to the DE2-115 push-button PIO: an Avalon-MM slave that synchronises a WIDTH-bit key bus, optionally debounces each channel, and latches selected edges into a per-bit edge-capture register. It adds a per-bit interrupt mask, an `irq` output, a selectable edge type, and write-1-to-clear capture bits. It sits between the board KEY pins and the Nios II data master / interrupt controller.

## Interface
- `WIDTH`, 4: number of key channels, 1..32.
- `EDGE_TYPE`, 1: edge captured; 0 = rising, 1 = falling (active-low keys), 2 = any.
- `DEBOUNCE_CYCLES`, 50000: cycles a synchronised level must hold before it is accepted; minimum 1. Used only when debounce is compiled in.
- `clk` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-high; all flops cleared on assertion.
- `address` in 2: register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `in_port` in WIDTH: raw key inputs, asynchronous to `clk`.
- `readdata` out 32: registered read data; bits above WIDTH read 0.
- `irq` out 1: level interrupt, high while any unmasked capture bit is set.

## Operation
- Registers:
  - 0 = DATA (debounced level, read-only).
  - 1 = reserved (reads 0, writes ignored).
  - 2 = IRQ_MASK (read/write, WIDTH bits).
  - 3 = EDGE_CAPTURE (read; writing 1 to a bit clears that bit, writing 0 leaves it unchanged).
- Write strobe = `chipselect & ~write_n`.
- Input path per channel: two-flop synchroniser `sync1 -> sync2`, then debounce stage producing `deb`, then `deb_d` (one-cycle delay).
- Debounce state machine, per channel:
  - Counter width is clog2(DEBOUNCE_CYCLES) bits, minimum 1.
  - IDLE (`sync2 == deb`): counter held at 0.
  - COUNT (`sync2 != deb`): counter increments each cycle.
  - If `sync2` returns to `deb` during COUNT, the counter clears to 0 and the state returns to IDLE.
  - When the counter equals DEBOUNCE_CYCLES-1 and `sync2 != deb` still holds, `deb <= sync2`, the counter clears, and the state returns to IDLE.
- Edge detect:
  - rising = `deb & ~deb_d`
  - falling = `~deb & deb_d`
  - any = `deb ^ deb_d`
  - Selected by EDGE_TYPE.
- Capture: a bit sets on a detected edge and clears on a write-1 to that bit. If both happen in the same cycle, the set wins and the bit stays 1.
- `irq = |(EDGE_CAPTURE & IRQ_MASK)`. It is combinational from registers only, so it is glitch-free.
- `readdata` registers the addressed register every cycle, regardless of `chipselect`.
- Reset values:
  - `readdata`, `irq`, IRQ_MASK, EDGE_CAPTURE, and debounce counters are all 0.
  - `sync1`, `sync2`, `deb`, and `deb_d` reset to all-ones. Released keys are high, so no falling edge is captured after reset.

## Timing
- Read latency is 1 cycle: `address` sampled at edge N gives data on `readdata` after edge N.
- Write effect is visible in the register after the write edge. A read of the same register in the next cycle returns the new value.
- An `in_port` change sampled at edge 0 behaves as follows:
  - `sync2` changes at edge 1.
  - With debounce, `deb` changes at edge 1+DEBOUNCE_CYCLES; without, at edge 1.
  - The capture bit and `irq` change one edge after `deb`: edge 2+DEBOUNCE_CYCLES with debounce, edge 2 without.
- A pulse shorter than DEBOUNCE_CYCLES cycles at `sync2` never reaches `deb`.
- Mask changes affect `irq` right after the write edge. Unmasking an already-set capture bit raises `irq` immediately.
- Asserting `reset` mid-count drops `irq` and clears `readdata` asynchronously. After release, the first capture needs a full debounce period.

## Configuration
- `KEY_PIO_DEBOUNCE_EN` defined: the debounce counters and state machine are instantiated, and DEBOUNCE_CYCLES is honoured.
- Not defined: `deb = sync2`, no counters are built, DEBOUNCE_CYCLES is ignored, and the edge-to-capture latency is 2 cycles.
- The register map and reset values are identical in both builds.

## Test plan
- Reset, then read addresses 0..3 (WIDTH=4): required responses are 0x0000000F, 0x0, 0x0, 0x0; `irq` = 0.
- Debounce build, DEBOUNCE_CYCLES=4, EDGE_TYPE=1, IRQ_MASK=0x1. Drive `in_port[0]` 1->0 before edge 0: EDGE_CAPTURE reads 0x1 after edge 6 and `irq` rises after edge 6. Write 0x1 to address 3: `irq` falls after the write edge.
- Debounce build, DEBOUNCE_CYCLES=4. A 3-cycle low glitch on `in_port[2]` gives no capture and DATA stays 0xF. A 4-cycle low gives capture bit 2.
- Issue a write-1-clear to bit 1 on the same cycle as a new edge on bit 1: the bit reads 1 afterwards.
- EDGE_TYPE=2, IRQ_MASK=0: a press and release on bit 3 sets capture 0x8 with `irq` held 0. Write IRQ_MASK=0x8: `irq` = 1 in the next cycle. Writing 0x7 to address 3 leaves 0x8 set.
- Non-debounce build: an edge on `in_port[1]` before edge 0 gives capture after edge 2. Assert `reset` while capture is set: `irq` and `readdata` go 0 immediately.

Source files
------------

// File: rtl/key_pio_irq.sv
// key_pio_irq: Avalon-MM push-button PIO with per-bit edge capture and a
// maskable level interrupt. Each key channel is synchronised, optionally
// debounced, and edge-detected. Capture bits are cleared by writing 1.
// Optional feature macro: KEY_PIO_DEBOUNCE_EN builds the per-channel
// debounce counters. Without it the synchronised level is used directly.
//
// Register map (address):
//   0 DATA          debounced level, read-only
//   1 reserved      reads 0, writes ignored
//   2 IRQ_MASK      read/write
//   3 EDGE_CAPTURE  read, write-1-to-clear
module key_pio_irq #(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] cap_clr;
  logic [31:0]      rd_mux;
  logic             wr;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign unused_wd = ^writedata;

  // Two-flop synchroniser plus the one-cycle delayed debounced level.
  // Released keys read high, so everything starts at all-ones to avoid
  // a spurious falling edge coming out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      deb_d <= '1;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      deb_d <= deb;
    end
  end

`ifdef KEY_PIO_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } deb_state_t;

  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    deb_state_t    state;
    deb_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          deb_q;
    logic          deb_nxt;

    assign deb[i] = deb_q;

    // Debounce state, counter and accepted level for this channel.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state <= IDLE;
        cnt   <= '0;
        deb_q <= 1'b1;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
        deb_q <= deb_nxt;
      end
    end

    // A new level is accepted only after it has differed from the current
    // one for DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      deb_nxt   = deb_q;
      case (state)
        IDLE: begin
          if (sync2[i] != deb_q) begin
            if (CNT_MAX == '0) begin
              deb_nxt = sync2[i];
            end else begin
              state_nxt = COUNT;
              cnt_nxt   = CW'(1);
            end
          end
        end
        COUNT: begin
          if (sync2[i] == deb_q) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == CNT_MAX) begin
            deb_nxt   = sync2[i];
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end
`else
  logic unused_cfg;

  assign deb        = sync2;
  assign unused_cfg = (DEBOUNCE_CYCLES > 0);
`endif

  // Edge selection is fixed at elaboration by EDGE_TYPE.
  always_comb begin
    case (EDGE_TYPE)
      0:       edge_det = deb & ~deb_d;
      1:       edge_det = ~deb & deb_d;
      default: edge_det = deb ^ deb_d;
    endcase
  end

  // Write-1-to-clear mask for the capture register.
  always_comb begin
    cap_clr = '0;
    if (wr && (address == 2'd3)) begin
      cap_clr = writedata[WIDTH-1:0];
    end
  end

  // Read multiplexer; unused upper bits and the reserved slot read 0.
  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = deb;
      2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
      2'd3:    rd_mux[WIDTH-1:0] = edge_cap;
      default: rd_mux = '0;
    endcase
  end

  // Mask, capture and registered read data. A new edge wins over a clear
  // arriving in the same cycle so no event is ever lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask <= '0;
      edge_cap <= '0;
      readdata <= '0;
    end else begin
      if (wr && (address == 2'd2)) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      edge_cap <= (edge_cap & ~cap_clr) | edge_det;
      readdata <= rd_mux;
    end
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_key_pio_irq.sv
// Bench for key_pio_irq: two instances (falling-edge and any-edge) share the
// same bus and keys, compared every cycle against a behavioural model, plus
// directed checks with literal expectations.
module tb_key_pio_irq;

  localparam int DEB = 4;
`ifdef KEY_PIO_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
  localparam int LAT    = 2 + DEB;
`else
  localparam bit DEB_EN = 1'b0;
  localparam int LAT    = 2;
`endif

  logic        clk        = 1'b0;
  logic        reset      = 1'b0;
  logic [1:0]  address    = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = 32'h0;
  logic [3:0]  in_port    = 4'hF;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  key_pio_irq #(.WIDTH(4), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(DEB)) dut_fall (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0));

  key_pio_irq #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(DEB)) dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd1), .irq(irq1));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Keys pass through two sampling stages; with debounce, a level is taken
  // once the last DEB synchronised samples all disagree with the held level.
  logic [3:0]  m_sync1, m_sync2, m_deb, m_debd, m_mask;
  logic [3:0]  m_cap [2];
  logic [31:0] m_rd  [2];
  logic [3:0]  win   [DEB-1];
  logic        m_ready = 1'b0;

  logic [3:0]  n_d, n_clr, n_mask, n_deb;
  logic [3:0]  n_cap [2];
  logic [31:0] n_rd  [2];
  logic        m_wr;

  always_comb begin : model_next
    logic run;
    run    = 1'b0;
    m_wr   = chipselect & ~write_n;
    n_d    = DEB_EN ? m_deb : m_sync2;
    n_clr  = (m_wr && address == 2'd3) ? writedata[3:0] : 4'h0;
    n_mask = (m_wr && address == 2'd2) ? writedata[3:0] : m_mask;
    for (int k = 0; k < 2; k++) begin
      n_rd[k] = 32'h0;
      if (address == 2'd0) n_rd[k] = {28'h0, n_d};
      if (address == 2'd2) n_rd[k] = {28'h0, m_mask};
      if (address == 2'd3) n_rd[k] = {28'h0, m_cap[k]};
      n_cap[k] = (m_cap[k] & ~n_clr) |
                 ((k == 0) ? (~n_d & m_debd) : (n_d ^ m_debd));
    end
    n_deb = m_deb;
    for (int i = 0; i < 4; i++) begin
      run = (m_sync2[i] != m_deb[i]);
      for (int j = 0; j < DEB - 1; j++) run = run & (win[j][i] != m_deb[i]);
      if (run) n_deb[i] = ~m_deb[i];
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sync1 <= 4'hF; m_sync2 <= 4'hF; m_deb <= 4'hF; m_debd <= 4'hF;
      m_mask  <= 4'h0;
      for (int k = 0; k < 2; k++) begin
        m_cap[k] <= 4'h0;
        m_rd[k]  <= 32'h0;
      end
      for (int j = 0; j < DEB - 1; j++) win[j] <= 4'hF;
      m_ready <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_cap[k] <= n_cap[k];
        m_rd[k]  <= n_rd[k];
      end
      m_mask <= n_mask;
      win[0] <= m_sync2;
      for (int j = 1; j < DEB - 1; j++) win[j] <= win[j-1];
      m_deb   <= n_deb;
      m_debd  <= n_d;
      m_sync2 <= m_sync1;
      m_sync1 <= in_port;
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(posedge clk) begin
    #1;
    if (m_ready && !reset) begin
      chk("model_rd_fall", rd0, m_rd[0]);
      chk("model_rd_any",  rd1, m_rd[1]);
      chk("model_irq_fall", 32'(irq0), 32'(|(m_cap[0] & m_mask)));
      chk("model_irq_any",  32'(irq1), 32'(|(m_cap[1] & m_mask)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic read_chk(input string nm, input logic [1:0] a,
                          input logic [31:0] e0, input logic [31:0] e1);
    @(negedge clk);
    address = a;
    @(posedge clk);
    #1;
    chk({nm, "_fall"}, rd0, e0);
    chk({nm, "_any"},  rd1, e1);
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rd_fall", rd0, 32'h0);
    chk("rst_irq_fall", 32'(irq0), 32'h0);
    reset = 1'b0;
    read_chk("rst_data", 2'd0, 32'hF, 32'hF);
    read_chk("rst_rsv",  2'd1, 32'h0, 32'h0);
    read_chk("rst_mask", 2'd2, 32'h0, 32'h0);
    read_chk("rst_cap",  2'd3, 32'h0, 32'h0);
    chk("rst_irq_any", 32'(irq1), 32'h0);

    // Falling edge on bit 0 with mask 0x1, then write-1-clear.
    bus_write(2'd2, 32'h1);
    @(negedge clk);
    address = 2'd3;
    in_port = 4'hE;
    for (int n = 0; n <= LAT + 1; n++) begin
      @(posedge clk);
      #1;
      if (n == LAT - 1) chk("fall_irq_early", 32'(irq0), 32'h0);
      if (n == LAT) begin
        chk("fall_irq", 32'(irq0), 32'h1);
        chk("fall_irq_any", 32'(irq1), 32'h1);
      end
      if (n == LAT + 1) chk("fall_cap", rd0, 32'h1);
    end
    bus_write(2'd3, 32'h1);
    chk("w1c_irq_fall", 32'(irq0), 32'h0);
    chk("w1c_irq_any",  32'(irq1), 32'h0);
    @(negedge clk);
    in_port = 4'hF;
    repeat (LAT + 2) @(negedge clk);
    read_chk("rise_cap", 2'd3, 32'h0, 32'h1);
    bus_write(2'd3, 32'hF);

    // Short glitch then a full-length pulse on bit 2.
    @(negedge clk);
    address = 2'd0;
    in_port = 4'hB;
    repeat (3) @(negedge clk);
    in_port = 4'hF;
    repeat (LAT + 2) @(negedge clk);
    read_chk("glitch_data", 2'd0, 32'hF, 32'hF);
    read_chk("glitch_cap", 2'd3, DEB_EN ? 32'h0 : 32'h4, DEB_EN ? 32'h0 : 32'h4);
    bus_write(2'd3, 32'hF);
    @(negedge clk);
    in_port = 4'hB;
    repeat (4) @(negedge clk);
    in_port = 4'hF;
    repeat (LAT + 2) @(negedge clk);
    read_chk("pulse_cap", 2'd3, 32'h4, 32'h4);
    bus_write(2'd3, 32'hF);

    // Clear on bit 1 in the same cycle its edge is captured: set wins.
    @(negedge clk);
    in_port = 4'hD;
    repeat (LAT - 1) @(negedge clk);
    bus_write(2'd3, 32'h2);
    read_chk("set_wins", 2'd3, 32'h2, 32'h2);
    bus_write(2'd3, 32'h2);
    read_chk("clr_b1", 2'd3, 32'h0, 32'h0);
    @(negedge clk);
    in_port = 4'hF;
    repeat (LAT + 2) @(negedge clk);
    bus_write(2'd3, 32'hF);

    // Press and release on bit 3 while masked, then unmask.
    bus_write(2'd2, 32'h0);
    @(negedge clk);
    in_port = 4'h7;
    repeat (LAT + 2) @(negedge clk);
    in_port = 4'hF;
    repeat (LAT + 2) @(negedge clk);
    chk("any_masked_irq", 32'(irq1), 32'h0);
    read_chk("any_cap", 2'd3, 32'h8, 32'h8);
    bus_write(2'd2, 32'h8);
    chk("unmask_irq_any",  32'(irq1), 32'h1);
    chk("unmask_irq_fall", 32'(irq0), 32'h1);
    bus_write(2'd3, 32'h7);
    read_chk("w0_keeps", 2'd3, 32'h8, 32'h8);
    bus_write(2'd3, 32'h8);
    chk("any_clr_irq", 32'(irq1), 32'h0);

    // Asynchronous reset while a capture is pending.
    bus_write(2'd2, 32'h2);
    @(negedge clk);
    address = 2'd3;
    in_port = 4'hD;
    repeat (LAT + 2) @(negedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_irq", 32'(irq0), 32'h1);
    chk("pre_rst_rd", rd0, 32'h2);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_irq_fall", 32'(irq0), 32'h0);
    chk("async_rst_irq_any",  32'(irq1), 32'h0);
    chk("async_rst_rd", rd0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n <= LAT + 1; n++) begin
      @(posedge clk);
      #1;
      if (n == LAT) chk("post_rst_cap_early", rd0, 32'h0);
      if (n == LAT + 1) chk("post_rst_cap", rd0, 32'h2);
    end
    @(negedge clk);
    in_port = 4'hF;
    repeat (LAT + 3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
